// File: rtl/phaser_tap_ctrl_mc.sv
// ---------------------------------------------------------------------------
// phaser_tap_ctrl_mc
//   Multi-lane phaser delay-tap controller. Each lane keeps a fine and a
//   coarse tap counter that the DDR PHY calibration sequencer can step, load
//   and read back. After every accepted tap change the lane is locked for
//   SETTLE_CYCLES cycles so the delay line can settle. The block also has a
//   programmable divided-clock enable (DIVCE) with a synchronous divider reset
//   and an optional resync on a rising edge of SYNCIN.
//
//   Optional build macro: PHASER_TAP_WRAP_EN
//     defined   - fine steps wrap 0 <-> FINE_MAX and carry/borrow into coarse
//     undefined - fine and coarse taps saturate independently
//
// Ports
//   SYSCLK, RST_N          clock, asynchronous active-low reset
//   LANE_SEL               target lane for commands and reads
//   FINEENABLE/FINEINC     fine step request / direction (1 = up)
//   COARSEENABLE/COARSEINC coarse step request / direction (1 = up)
//   COUNTERLOADEN/VAL      load fine tap of selected lane (clamped to FINE_MAX)
//   COUNTERREADEN          read fine tap of selected lane, latency 1
//   COUNTERREADVAL/VLD     read data and its valid pulse
//   FINEOVERFLOW           fine saturation / clamp / wrap pulse
//   COARSEOVERFLOW         coarse saturation pulse
//   REJECT                 command dropped (lane busy or lane out of range)
//   BUSY                   per-lane settle lockout
//   FINE_TAP, COARSE_TAP   live taps, lane 0 in the LSBs
//   DIVIDERST, SYNCIN      divider reset, sync pulse
//   DIVCE                  one-cycle enable every CLKOUT_DIV cycles
// ---------------------------------------------------------------------------

// Per-lane tap state. The command decode is done once in the top; a lane only
// sees an accept strobe plus the already priority-resolved operation.
module phaser_tap_lane #(
    parameter int TAP_W         = 6,
    parameter int FINE_MAX      = 63,
    parameter int COARSE_MAX    = 63,
    parameter int FINE_INIT     = 0,
    parameter int COARSE_INIT   = 0,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic             op_load,
    input  logic             op_coarse,
    input  logic             op_fine,
    input  logic             inc_coarse,
    input  logic             inc_fine,
    input  logic [TAP_W-1:0] load_val,
    output logic [TAP_W-1:0] fine,
    output logic [TAP_W-1:0] coarse,
    output logic             busy,
    output logic             fine_ovf,
    output logic             coarse_ovf
);
    localparam logic [TAP_W-1:0] FMAX      = TAP_W'(FINE_MAX);
    localparam logic [TAP_W-1:0] CMAX      = TAP_W'(COARSE_MAX);
    localparam logic [TAP_W-1:0] TAP_ZERO  = '0;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    logic [TAP_W-1:0] fine_q, fine_d;
    logic [TAP_W-1:0] coarse_q, coarse_d;
    logic [CNT_W-1:0] settle_q, settle_d;

    always_comb begin
        fine_d     = fine_q;
        coarse_d   = coarse_q;
        fine_ovf   = 1'b0;
        coarse_ovf = 1'b0;
        settle_d   = (settle_q != '0) ? settle_q - 1'b1 : settle_q;
        if (acc) begin
            // Every accepted command restarts the lockout, even a saturated one.
            settle_d = SETTLE_LD;
            if (op_load) begin
                if (load_val > FMAX) begin
                    fine_d   = FMAX;
                    fine_ovf = 1'b1;
                end else begin
                    fine_d = load_val;
                end
            end else if (op_coarse) begin
                if (inc_coarse) begin
                    if (coarse_q == CMAX) coarse_ovf = 1'b1;
                    else                  coarse_d   = coarse_q + 1'b1;
                end else begin
                    if (coarse_q == TAP_ZERO) coarse_ovf = 1'b1;
                    else                      coarse_d   = coarse_q - 1'b1;
                end
            end else if (op_fine) begin
`ifdef PHASER_TAP_WRAP_EN
                // Wrap fine and carry/borrow into coarse; if coarse cannot
                // move, the whole step is refused and fine stays put.
                if (inc_fine) begin
                    if (fine_q != FMAX) begin
                        fine_d = fine_q + 1'b1;
                    end else if (coarse_q == CMAX) begin
                        coarse_ovf = 1'b1;
                    end else begin
                        fine_d   = TAP_ZERO;
                        coarse_d = coarse_q + 1'b1;
                        fine_ovf = 1'b1;
                    end
                end else begin
                    if (fine_q != TAP_ZERO) begin
                        fine_d = fine_q - 1'b1;
                    end else if (coarse_q == TAP_ZERO) begin
                        coarse_ovf = 1'b1;
                    end else begin
                        fine_d   = FMAX;
                        coarse_d = coarse_q - 1'b1;
                        fine_ovf = 1'b1;
                    end
                end
`else
                if (inc_fine) begin
                    if (fine_q == FMAX) fine_ovf = 1'b1;
                    else                fine_d   = fine_q + 1'b1;
                end else begin
                    if (fine_q == TAP_ZERO) fine_ovf = 1'b1;
                    else                    fine_d   = fine_q - 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_q   <= TAP_W'(FINE_INIT);
            coarse_q <= TAP_W'(COARSE_INIT);
            settle_q <= '0;
        end else begin
            fine_q   <= fine_d;
            coarse_q <= coarse_d;
            settle_q <= settle_d;
        end
    end

    assign fine   = fine_q;
    assign coarse = coarse_q;
    assign busy   = (settle_q != '0);
endmodule

module phaser_tap_ctrl_mc #(
    parameter int NUM_LANES       = 4,
    parameter int LANE_W          = 2,
    parameter int TAP_W           = 6,
    parameter int FINE_MAX        = 63,
    parameter int COARSE_MAX      = 63,
    parameter int FINE_INIT       = 0,
    parameter int COARSE_INIT     = 0,
    parameter int SETTLE_CYCLES   = 3,
    parameter int CLKOUT_DIV      = 4,
    parameter int SYNC_IN_DIV_RST = 0
) (
    input  logic                       SYSCLK,
    input  logic                       RST_N,
    input  logic [LANE_W-1:0]          LANE_SEL,
    input  logic                       FINEENABLE,
    input  logic                       FINEINC,
    input  logic                       COARSEENABLE,
    input  logic                       COARSEINC,
    input  logic                       COUNTERLOADEN,
    input  logic [TAP_W-1:0]           COUNTERLOADVAL,
    input  logic                       COUNTERREADEN,
    output logic [TAP_W-1:0]           COUNTERREADVAL,
    output logic                       COUNTERREADVLD,
    output logic                       FINEOVERFLOW,
    output logic                       COARSEOVERFLOW,
    output logic                       REJECT,
    output logic [NUM_LANES-1:0]       BUSY,
    output logic [NUM_LANES*TAP_W-1:0] FINE_TAP,
    output logic [NUM_LANES*TAP_W-1:0] COARSE_TAP,
    input  logic                       DIVIDERST,
    input  logic                       SYNCIN,
    output logic                       DIVCE
);
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int DIV_W = $clog2(CLKOUT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKOUT_DIV - 1);
    localparam bit SYNC_RST_EN = (SYNC_IN_DIV_RST != 0);

    logic [NUM_LANES-1:0]            lane_hit;
    logic [NUM_LANES-1:0]            lane_acc;
    logic [NUM_LANES-1:0]            lane_busy;
    logic [NUM_LANES-1:0]            lane_fovf;
    logic [NUM_LANES-1:0]            lane_covf;
    logic [NUM_LANES-1:0][TAP_W-1:0] lane_fine;
    logic [NUM_LANES-1:0][TAP_W-1:0] lane_coarse;

    logic             lane_ok, busy_sel, cmd_any, accept;
    logic             op_load, op_coarse, op_fine;
    logic [TAP_W-1:0] rd_mux;

    logic             reject_q, reject_d;
    logic             fovf_q, fovf_d;
    logic             covf_q, covf_d;
    logic [TAP_W-1:0] rd_val_q, rd_val_d;
    logic             rd_vld_q, rd_vld_d;
    logic             syncin_q, syncin_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             div_rst;

    // One-hot lane decode; an out-of-range LANE_SEL matches no lane, which
    // makes it reject commands and read back zero without special casing.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_hit[g] = (LANE_SEL == LANE_W'(g));
        assign lane_acc[g] = accept & lane_hit[g];

        phaser_tap_lane #(
            .TAP_W        (TAP_W),
            .FINE_MAX     (FINE_MAX),
            .COARSE_MAX   (COARSE_MAX),
            .FINE_INIT    (FINE_INIT),
            .COARSE_INIT  (COARSE_INIT),
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clk       (SYSCLK),
            .rst_n     (RST_N),
            .acc       (lane_acc[g]),
            .op_load   (op_load),
            .op_coarse (op_coarse),
            .op_fine   (op_fine),
            .inc_coarse(COARSEINC),
            .inc_fine  (FINEINC),
            .load_val  (COUNTERLOADVAL),
            .fine      (lane_fine[g]),
            .coarse    (lane_coarse[g]),
            .busy      (lane_busy[g]),
            .fine_ovf  (lane_fovf[g]),
            .coarse_ovf(lane_covf[g])
        );
    end

    always_comb begin
        lane_ok   = |lane_hit;
        busy_sel  = |(lane_hit & lane_busy);
        op_load   = COUNTERLOADEN;
        op_coarse = ~COUNTERLOADEN & COARSEENABLE;
        op_fine   = ~COUNTERLOADEN & ~COARSEENABLE & FINEENABLE;
        cmd_any   = COUNTERLOADEN | COARSEENABLE | FINEENABLE;
        accept    = cmd_any & lane_ok & ~busy_sel;
        reject_d  = cmd_any & ~accept;
        // Only the accepted lane can raise an overflow in a given cycle.
        fovf_d    = |lane_fovf;
        covf_d    = |lane_covf;

        rd_mux = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_hit[i]) rd_mux = lane_fine[i];
        end
        // Sampled from the current tap, so a same-cycle write is not visible.
        rd_val_d = COUNTERREADEN ? rd_mux : rd_val_q;
        rd_vld_d = COUNTERREADEN;
    end

    // Divider: free-running 0..CLKOUT_DIV-1, restarted by DIVIDERST or by a
    // SYNCIN rising edge when that resync is enabled.
    always_comb begin
        syncin_d  = SYNCIN;
        div_rst   = DIVIDERST | (SYNC_RST_EN & SYNCIN & ~syncin_q);
        if (div_rst)                     div_cnt_d = '0;
        else if (div_cnt_q == DIV_LAST)  div_cnt_d = '0;
        else                             div_cnt_d = div_cnt_q + 1'b1;
        DIVCE = (div_cnt_q == DIV_LAST) & ~div_rst;
    end

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            reject_q  <= 1'b0;
            fovf_q    <= 1'b0;
            covf_q    <= 1'b0;
            rd_val_q  <= '0;
            rd_vld_q  <= 1'b0;
            syncin_q  <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            reject_q  <= reject_d;
            fovf_q    <= fovf_d;
            covf_q    <= covf_d;
            rd_val_q  <= rd_val_d;
            rd_vld_q  <= rd_vld_d;
            syncin_q  <= syncin_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign REJECT         = reject_q;
    assign FINEOVERFLOW   = fovf_q;
    assign COARSEOVERFLOW = covf_q;
    assign COUNTERREADVAL = rd_val_q;
    assign COUNTERREADVLD = rd_vld_q;
    assign BUSY           = lane_busy;
    assign FINE_TAP       = lane_fine;
    assign COARSE_TAP     = lane_coarse;
endmodule

// File: tb/tb_phaser_tap_ctrl_mc.sv
// Bench for phaser_tap_ctrl_mc: a table of per-cycle command records with
// their expected registered outputs, pushed to a scoreboard queue when driven
// and checked after the edge, followed by hand-written divider and
// reset-during-lockout sequences.
module tb_phaser_tap_ctrl_mc;
    localparam int NL = 4;
    localparam int LW = 3;
    localparam int TW = 7;
`ifdef PHASER_TAP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             SYSCLK = 1'b0;
    logic             RST_N;
    logic [LW-1:0]    LANE_SEL;
    logic             FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
    logic             COUNTERLOADEN, COUNTERREADEN;
    logic [TW-1:0]    COUNTERLOADVAL;
    logic [TW-1:0]    COUNTERREADVAL;
    logic             COUNTERREADVLD, FINEOVERFLOW, COARSEOVERFLOW, REJECT;
    logic [NL-1:0]    BUSY;
    logic [NL*TW-1:0] FINE_TAP, COARSE_TAP;
    logic             DIVIDERST, SYNCIN, DIVCE;

    phaser_tap_ctrl_mc #(
        .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW), .FINE_MAX(63), .COARSE_MAX(63),
        .FINE_INIT(0), .COARSE_INIT(0), .SETTLE_CYCLES(3), .CLKOUT_DIV(5),
        .SYNC_IN_DIV_RST(1)
    ) dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N), .LANE_SEL(LANE_SEL),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
        .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL),
        .COUNTERREADVLD(COUNTERREADVLD), .FINEOVERFLOW(FINEOVERFLOW),
        .COARSEOVERFLOW(COARSEOVERFLOW), .REJECT(REJECT), .BUSY(BUSY),
        .FINE_TAP(FINE_TAP), .COARSE_TAP(COARSE_TAP),
        .DIVIDERST(DIVIDERST), .SYNCIN(SYNCIN), .DIVCE(DIVCE)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        int lane;
        bit ld; int lv; bit ce; bit ci; bit fe; bit fi; bit rd;
        bit rej; bit fo; bit co; bit vld; int rv;
        bit chk; int tap; int ctap; bit busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input int lane, input bit ld, input int lv,
                                input bit ce, input bit ci, input bit fe,
                                input bit fi, input bit rd, input bit rej,
                                input bit fo, input bit co, input bit vld,
                                input int rv, input bit chk, input int tap,
                                input int ctap, input bit busy);
        vec_t v;
        v.lane = lane; v.ld = ld; v.lv = lv; v.ce = ce; v.ci = ci;
        v.fe = fe; v.fi = fi; v.rd = rd; v.rej = rej; v.fo = fo; v.co = co;
        v.vld = vld; v.rv = rv; v.chk = chk; v.tap = tap; v.ctap = ctap;
        v.busy = busy;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input int lane, input int tap, input int ctap,
                                 input bit busy);
        add(lane, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tap, ctap, busy);
    endfunction

    // Three idle cycles after an accepted command: lockout reads 1,1,0.
    function automatic void settle(input int lane, input int tap, input int ctap);
        idle(lane, tap, ctap, 1);
        idle(lane, tap, ctap, 1);
        idle(lane, tap, ctap, 0);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_idle();
        LANE_SEL = '0; FINEENABLE = 0; FINEINC = 0; COARSEENABLE = 0;
        COARSEINC = 0; COUNTERLOADEN = 0; COUNTERLOADVAL = '0;
        COUNTERREADEN = 0; DIVIDERST = 0; SYNCIN = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        int   tap, ctap;
        bit   ok;
        LANE_SEL = LW'(v.lane); COUNTERLOADEN = v.ld; COUNTERLOADVAL = TW'(v.lv);
        COARSEENABLE = v.ce; COARSEINC = v.ci; FINEENABLE = v.fe; FINEINC = v.fi;
        COUNTERREADEN = v.rd;
        sb.push_back(v);
        @(posedge SYSCLK); #1;
        e = sb.pop_front();
        ok = (REJECT == e.rej) && (FINEOVERFLOW == e.fo) &&
             (COARSEOVERFLOW == e.co) && (COUNTERREADVLD == e.vld);
        if (e.vld && int'(COUNTERREADVAL) != e.rv) ok = 0;
        tap = -1; ctap = -1;
        if (e.chk) begin
            tap  = int'(FINE_TAP[e.lane*TW +: TW]);
            ctap = int'(COARSE_TAP[e.lane*TW +: TW]);
            if (tap != e.tap || ctap != e.ctap || BUSY[e.lane] != e.busy) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vec%0d lane%0d: got rej=%0b fo=%0b co=%0b vld=%0b rv=%0d tap=%0d ctap=%0d busy=%b expected rej=%0b fo=%0b co=%0b vld=%0b rv=%0d tap=%0d ctap=%0d busy=%0b",
                     idx, e.lane, REJECT, FINEOVERFLOW, COARSEOVERFLOW,
                     COUNTERREADVLD, COUNTERREADVAL, tap, ctap, BUSY,
                     e.rej, e.fo, e.co, e.vld, e.rv, e.tap, e.ctap, e.busy);
        end
    endtask

    initial begin
        int c0;
        c0 = WRAP ? 1 : 0;   // lane 0 coarse after the step-up at fine max

        // Five fine ups on lane 2 spaced by the lockout, then read lanes.
        for (int k = 1; k <= 5; k++) begin
            add(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, k, 0, 1);
            settle(2, k, 0);
        end
        add(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 1, 5, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Back-to-back step on lane 1: second one rejected, lockout 3 cycles.
        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        idle(1, 1, 0, 1);
        idle(1, 1, 0, 0);
        // Lockout is per lane: lane 2 accepted while lane 1 is busy.
        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
        add(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1);
        settle(2, 4, 0);
        add(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1);
        settle(2, 4, 1);
        // Load clamp, step-up at max, step-down at zero, coarse saturation.
        add(0, 1, 70, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 63, 0, 1);
        settle(0, 63, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, WRAP ? 0 : 63, c0, 1);
        settle(0, WRAP ? 0 : 63, c0);
        add(3, 0, 0, 0, 0, 1, 0, 0, 0, !WRAP, WRAP, 0, 0, 1, 0, 0, 1);
        settle(3, 0, 0);
        add(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        settle(3, 0, 0);
        add(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        settle(3, 0, 1);
        add(3, 1, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 63, 1, 1);
        settle(3, 63, 1);
        // Load beats coarse and fine; read next cycle bypasses the lockout.
        add(0, 1, 10, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 10, c0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 10, 1, 10, c0, 1);
        idle(0, 10, c0, 1);
        idle(0, 10, c0, 0);
        // Read in the same cycle as a step returns the old value.
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 10, 1, 11, c0, 1);
        settle(0, 11, c0);
        // Out-of-range lanes: commands rejected, reads return 0.
        add(5, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 11, 1, 11, c0, 0);
`ifdef PHASER_TAP_WRAP_EN
        // Wrap with carry and borrow on lane 1 (fine 2, coarse 0 here).
        add(1, 1, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 63, 0, 1);
        settle(1, 63, 0);
        for (int k = 1; k <= 4; k++) begin
            add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 63, k, 1);
            settle(1, 63, k);
        end
        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 5, 1);
        settle(1, 0, 5);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 63, 4, 1);
        settle(1, 63, 4);
`endif

        // Reset state.
        drive_idle();
        RST_N = 1'b0;
        #12;
        check("rst_busy", int'(BUSY), 0);
        check("rst_fine", int'(FINE_TAP), 0);
        check("rst_coarse", int'(COARSE_TAP), 0);
        check("rst_pulses", int'({REJECT, FINEOVERFLOW, COARSEOVERFLOW, COUNTERREADVLD}), 0);
        check("rst_rdval", int'(COUNTERREADVAL), 0);
        check("rst_divce", int'(DIVCE), 0);
        @(negedge SYSCLK);
        RST_N = 1'b1;
        @(posedge SYSCLK); #1;

        foreach (tbl[i]) run_vec(i, tbl[i]);
        drive_idle();

        // Divider: DIVIDERST, SYNCIN rise mid-period (held two cycles so only
        // the edge counts), DIVIDERST on the terminal count masks DIVCE.
        for (int i = 0; i < 24; i++) begin
            DIVIDERST = (i == 0 || i == 18);
            SYNCIN    = (i == 8 || i == 9);
            @(negedge SYSCLK);
            check($sformatf("divce_c%0d", i), int'(DIVCE),
                  (i == 5 || i == 13 || i == 23) ? 1 : 0);
            @(posedge SYSCLK); #1;
        end
        drive_idle();

        // Asynchronous reset in the middle of a lockout.
        LANE_SEL = 3'd2; FINEENABLE = 1; FINEINC = 1;
        @(posedge SYSCLK); #1;
        drive_idle();
        check("lock_busy", int'(BUSY), 4);
        check("lock_tap2", int'(FINE_TAP[2*TW +: TW]), 5);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_busy", int'(BUSY), 0);
        check("arst_fine", int'(FINE_TAP), 0);
        check("arst_coarse", int'(COARSE_TAP), 0);
        @(negedge SYSCLK);
        RST_N = 1'b1;
        @(posedge SYSCLK); #1;
        check("post_rst_busy", int'(BUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
